uart_tx_serializer: RTL and testbench

- Byte-to-serial UART transmitter; the output-direction counterpart to the project's input/adder datapath.
- Accepts a parallel byte over a valid/ready handshake and drives one asynchronous serial line: start bit, LSB-first data, optional even parity, stop bit(s).
- Instantiated inside the tt_um top-level wrapper: tx drives a uo_out bit, busy drives a uio_out bit with the matching uio_oe bit = 1.
- The wrapper derives rst from rst_n.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_counter.sv | 29 ++
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Even parity over the low `width` bits; the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data, input int width);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (int'(i) < width) p ^= data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; bit_tick marks the last cycle of each bit period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Suppressed on clear so a handshake landing on a wrap cycle cannot shorten the start bit.
  assign bit_tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_W < 5 || DATA_W > 8 ||
        PARITY_EN < 0 || PARITY_EN > 1 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
      $error("uart_tx_serializer: illegal parameter set");
    end
  endgenerate

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        data_ext;
  logic              handshake;
  logic              bit_tick;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign handshake = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign tx        = tx_q;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (handshake),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= LINE_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // tx_d is the level of the bit being entered, so tx is registered yet changes on the bit edge.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    data_ext  = '0;
    data_ext[DATA_W-1:0] = in_data;

    case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        if (handshake) begin
          shift_d   = in_data;
          parity_d  = even_parity(data_ext, DATA_W);
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = LINE_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d   = STOP;
          tx_d      = LINE_IDLE;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (bit_tick) begin
          tx_d = LINE_IDLE;
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer over three configurations at CLKS_PER_BIT=4.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic [2:0] in_valid;
  logic [7:0] in_data [3];
  logic [2:0] in_ready;
  logic [2:0] tx;
  logic [2:0] busy;

  int vecs;
  int errs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: no parity, 1 stop; dut 1: even parity, 1 stop; dut 2: no parity, 2 stops
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]));

  // Presents a byte on dut d; must be called at a falling edge so the next rising edge accepts it.
  task automatic offer(input int d, input logic [7:0] data);
    in_data[d]  = data;
    in_valid[d] = 1'b1;
  endtask

  // Records tx per cycle while busy; optionally disturbs in_data/in_valid at cycle poke_at.
  task automatic capture(input int d, input int poke_at, output int len,
                         output logic [11:0] bits, output logic held);
    logic [199:0] log_tx;
    log_tx = '0;
    len    = 0;
    bits   = '0;
    held   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) in_valid[d] = 1'b0;
      if (i == poke_at) begin
        in_valid[d] = 1'b1;
        in_data[d]  = 8'hFF;
      end
      if (i == poke_at + 1) in_valid[d] = 1'b0;
      if (!busy[d]) break;
      log_tx[i] = tx[d];
      len++;
    end
    for (int b = 0; b < 12; b++) begin
      if (b * 4 < len) begin
        bits[b] = log_tx[b*4];
        for (int k = 1; k < 4; k++) begin
          if (b * 4 + k < len && log_tx[b*4+k] !== log_tx[b*4]) held = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 3'b111;
    for (int d = 0; d < 3; d++) in_data[d] = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (tx !== 3'b111) begin
        errs++;
        $display("FAIL reset_tx: got %b expected 111", tx);
      end
      vecs++;
      if (busy !== 3'b000) begin
        errs++;
        $display("FAIL reset_busy: got %b expected 000", busy);
      end
      vecs++;
      if (in_ready !== 3'b000) begin
        errs++;
        $display("FAIL reset_in_ready: got %b expected 000", in_ready);
      end
    end
    rst      = 1'b0;
    in_valid = 3'b000;
    #1;
    vecs++;
    if (in_ready !== 3'b111) begin
      errs++;
      $display("FAIL post_reset_in_ready: got %b expected 111", in_ready);
    end
    repeat (8) begin
      @(negedge clk);
      vecs++;
      if (tx !== 3'b111 || busy !== 3'b000) begin
        errs++;
        $display("FAIL post_reset_quiet: got tx=%b busy=%b expected tx=111 busy=000", tx, busy);
      end
    end
  endtask

  task automatic test_single_byte;
    int len;
    logic [11:0] bits;
    logic held;
    offer(0, 8'h55);
    capture(0, -1, len, bits, held);
    vecs++;
    if (len !== 40) begin
      errs++;
      $display("FAIL single_len: got %0d expected 40", len);
    end
    vecs++;
    if (bits !== 12'(10'b1010101010)) begin
      errs++;
      $display("FAIL single_bits: got %b expected %b", bits, 12'(10'b1010101010));
    end
    vecs++;
    if (held !== 1'b1) begin
      errs++;
      $display("FAIL single_hold: got %b expected 1", held);
    end
    vecs++;
    if (in_ready[0] !== 1'b1 || tx[0] !== 1'b1) begin
      errs++;
      $display("FAIL single_after: got in_ready=%b tx=%b expected 1 1", in_ready[0], tx[0]);
    end
  endtask

  task automatic test_parity;
    int len;
    logic [11:0] bits;
    logic held;
    offer(1, 8'h01);
    capture(1, -1, len, bits, held);
    vecs++;
    if (len !== 44) begin
      errs++;
      $display("FAIL parity01_len: got %0d expected 44", len);
    end
    vecs++;
    if (bits !== 12'(11'b11000000010) || held !== 1'b1) begin
      errs++;
      $display("FAIL parity01_bits: got %b held=%b expected %b held=1", bits, held, 12'(11'b11000000010));
    end
    offer(1, 8'h03);
    capture(1, -1, len, bits, held);
    vecs++;
    if (len !== 44) begin
      errs++;
      $display("FAIL parity03_len: got %0d expected 44", len);
    end
    vecs++;
    if (bits !== 12'(11'b10000000110) || held !== 1'b1) begin
      errs++;
      $display("FAIL parity03_bits: got %b held=%b expected %b held=1", bits, held, 12'(11'b10000000110));
    end
  endtask

  task automatic test_back_to_back;
    logic [81:0] log_tx;
    logic [81:0] log_busy;
    logic [9:0]  f1;
    logic [9:0]  f2;
    int idle_cnt;
    offer(0, 8'hA5);
    for (int i = 0; i < 82; i++) begin
      @(negedge clk);
      if (i == 0) in_data[0] = 8'h3C;
      if (i == 41) in_valid[0] = 1'b0;
      log_tx[i]   = tx[0];
      log_busy[i] = busy[0];
    end
    idle_cnt = 0;
    for (int i = 0; i < 81; i++) if (!log_busy[i]) idle_cnt++;
    for (int b = 0; b < 10; b++) begin
      f1[b] = log_tx[b*4];
      f2[b] = log_tx[41 + b*4];
    end
    vecs++;
    if (f1 !== 10'b1101001010) begin
      errs++;
      $display("FAIL b2b_frame1: got %b expected %b", f1, 10'b1101001010);
    end
    vecs++;
    if (f2 !== 10'b1001111000) begin
      errs++;
      $display("FAIL b2b_frame2: got %b expected %b", f2, 10'b1001111000);
    end
    vecs++;
    if (idle_cnt !== 1 || log_busy[40] !== 1'b0 || log_tx[40] !== 1'b1) begin
      errs++;
      $display("FAIL b2b_gap: got idle=%0d busy40=%b tx40=%b expected 1 0 1", idle_cnt, log_busy[40], log_tx[40]);
    end
    vecs++;
    if (log_busy[80] !== 1'b1 || log_busy[81] !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end: got busy80=%b busy81=%b expected 1 0", log_busy[80], log_busy[81]);
    end
  endtask

  task automatic test_mid_frame_disturb;
    int len;
    logic [11:0] bits;
    logic held;
    offer(0, 8'h55);
    capture(0, 10, len, bits, held);
    vecs++;
    if (len !== 40 || bits !== 12'(10'b1010101010) || held !== 1'b1) begin
      errs++;
      $display("FAIL disturb_frame: got len=%0d bits=%b held=%b expected 40 %b 1",
               len, bits, held, 12'(10'b1010101010));
    end
    repeat (6) begin
      @(negedge clk);
      vecs++;
      if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
        errs++;
        $display("FAIL disturb_no_second: got busy=%b tx=%b expected 0 1", busy[0], tx[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int len;
    logic [11:0] bits;
    logic held;
    offer(2, 8'h00);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 0) in_valid[2] = 1'b0;
    end
    vecs++;
    if (tx[2] !== 1'b0 || busy[2] !== 1'b1) begin
      errs++;
      $display("FAIL midrst_before: got tx=%b busy=%b expected 0 1", tx[2], busy[2]);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (tx[2] !== 1'b1 || busy[2] !== 1'b0 || in_ready[2] !== 1'b0) begin
      errs++;
      $display("FAIL midrst_async: got tx=%b busy=%b in_ready=%b expected 1 0 0", tx[2], busy[2], in_ready[2]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if (in_ready[2] !== 1'b1 || tx[2] !== 1'b1) begin
      errs++;
      $display("FAIL midrst_release: got in_ready=%b tx=%b expected 1 1", in_ready[2], tx[2]);
    end
    @(negedge clk);
    offer(2, 8'h80);
    capture(2, -1, len, bits, held);
    vecs++;
    if (len !== 44) begin
      errs++;
      $display("FAIL midrst_len: got %0d expected 44", len);
    end
    vecs++;
    if (bits !== 12'(11'b11100000000) || held !== 1'b1) begin
      errs++;
      $display("FAIL midrst_bits: got %b held=%b expected %b held=1", bits, held, 12'(11'b11100000000));
    end
  endtask

  initial begin
    vecs     = 0;
    errs     = 0;
    rst      = 1'b1;
    in_valid = 3'b000;
    for (int d = 0; d < 3; d++) in_data[d] = 8'h00;
    test_reset;
    test_single_byte;
    test_parity;
    test_back_to_back;
    test_mid_frame_disturb;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
